// File: rtl/fp_align_shift_round_pipe.sv
// Two-stage pipelined arithmetic right shifter with floor / half-up / half-even rounding.
// Define FP_ALIGN_STICKY_EN to expose sticky_o (OR of all bits shifted out).
module fp_align_shift_round_pipe #(
    parameter int M_W  = 16,
    parameter int SH_W = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [M_W-1:0]  m_i,
    input  logic [SH_W-1:0] shift_i,
    input  logic [1:0]      rnd_mode_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [M_W-1:0]  m_o
`ifdef FP_ALIGN_STICKY_EN
    ,
    output logic            sticky_o
`endif
);

    localparam logic [SH_W-1:0] FLUSH_SH = SH_W'(M_W);

    // Bit masks selecting the discarded bits and the guard position for this shift.
    logic [M_W-1:0] below_shift;
    logic [M_W-1:0] guard_pos;

    genvar gi;
    generate
        for (gi = 0; gi < M_W; gi++) begin : g_masks
            assign below_shift[gi] = (SH_W'(gi) < shift_i);
            assign guard_pos[gi]   = (SH_W'(gi + 1) == shift_i);
        end
    endgenerate

    logic signed [M_W-1:0] m_signed;
    logic [M_W-1:0]        align_t;
    logic                  align_g;
    logic                  align_s;

    assign m_signed = m_i;

    always_comb begin
        align_t = m_signed >>> shift_i;
        align_g = |(m_i & guard_pos);
        align_s = |(m_i & below_shift & ~guard_pos);
        // Shifting everything out flushes to zero regardless of sign.
        if (shift_i >= FLUSH_SH) begin
            align_t = '0;
            align_g = 1'b0;
            align_s = |m_i;
        end
    end

    logic            s1_valid_reg;
    logic [M_W-1:0]  s1_t_reg;
    logic            s1_g_reg;
    logic            s1_s_reg;
    logic [1:0]      s1_mode_reg;
    logic            s2_valid_reg;
    logic [M_W-1:0]  s2_m_reg;

    logic s1_adv;
    logic s2_adv;

    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_t_reg     <= '0;
            s1_g_reg     <= 1'b0;
            s1_s_reg     <= 1'b0;
            s1_mode_reg  <= 2'd0;
        end else if (s1_adv) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_t_reg    <= align_t;
                s1_g_reg    <= align_g;
                s1_s_reg    <= align_s;
                s1_mode_reg <= rnd_mode_i;
            end
        end
    end

    logic           round_inc;
    logic [M_W-1:0] round_m;

    always_comb begin
        round_inc = 1'b0;
        case (s1_mode_reg)
            2'd1:    round_inc = s1_g_reg;
            2'd2:    round_inc = s1_g_reg & (s1_s_reg | s1_t_reg[0]);
            default: round_inc = 1'b0;
        endcase
        // Cannot overflow: a set guard bit implies shift >= 1, leaving headroom in t.
        round_m = s1_t_reg + {{(M_W-1){1'b0}}, round_inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_m_reg     <= '0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_m_reg <= round_m;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign m_o       = s2_m_reg;

`ifdef FP_ALIGN_STICKY_EN
    logic s2_sticky_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sticky_reg <= 1'b0;
        end else if (s2_adv && s1_valid_reg) begin
            s2_sticky_reg <= s1_g_reg | s1_s_reg;
        end
    end

    assign sticky_o = s2_sticky_reg;
`endif

endmodule
